// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state encoding for the uart_tx arbiter
package uart_pkg;

    localparam int UART_BYTE_W      = 8;
    localparam int UART_FRAME_TICKS = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter: rotate, priority-encode, unrotate
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [N-1:0]     w_rot;
    logic [IDX_W-1:0] w_pos;

    function automatic logic [IDX_W-1:0] wrap(input int v);
        int r;
        r = (v >= N) ? v - N : v;
        return r[IDX_W-1:0];
    endfunction

    always_comb begin
        w_rot   = '0;
        w_pos   = '0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = |i_req;
        for (int i = 0; i < N; i++) begin
            w_rot[i] = i_req[wrap(int'(i_ptr) + i)];
        end
        // descending scan so the lowest rotated position (closest to the pointer) wins
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_pos = IDX_W'(i);
            end
        end
        o_idx = wrap(int'(i_ptr) + int'(w_pos));
        if (o_any) begin
            o_grant[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one uart_tx among byte-stream requesters
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int FRAME_TICKS = UART_FRAME_TICKS,
    parameter int HOLD_TICKS  = 16,
    parameter int IDX_W       = $clog2(N_REQ)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_tick,
    input  logic [N_REQ-1:0]             i_req_valid,
    input  logic [UART_BYTE_W*N_REQ-1:0] i_req_data,
    input  logic [N_REQ-1:0]             i_req_last,
    output logic [N_REQ-1:0]             o_req_ready,
    output logic                         o_tx_en,
    output logic [UART_BYTE_W-1:0]       o_tx_data,
    output logic [IDX_W-1:0]             o_grant_id,
    output logic                         o_busy
);

    localparam int CNT_MAX = (FRAME_TICKS > HOLD_TICKS) ? FRAME_TICKS : HOLD_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    arb_state_t             r_state;
    logic                   r_tx_en;
    logic [UART_BYTE_W-1:0] r_tx_data;
    logic [IDX_W-1:0]       r_grant_id;
    logic [IDX_W-1:0]       r_ptr;
    logic                   r_lock;
    logic [CNT_W-1:0]       r_cnt;

    logic [N_REQ-1:0]       w_arb_grant;
    logic [IDX_W-1:0]       w_arb_idx;
    logic                   w_arb_any;
    logic [N_REQ-1:0]       w_ready;
    logic [IDX_W-1:0]       w_sel_idx;
    logic [UART_BYTE_W-1:0] w_sel_data;
    logic                   w_sel_last;
    logic [IDX_W-1:0]       w_ptr_next;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_any   (w_arb_any)
    );

    always_comb begin
        w_ready = '0;
        if (i_rst_n) begin
            if (r_state == ST_IDLE) begin
                w_ready = w_arb_grant;
            end else if (r_state == ST_HOLD) begin
                w_ready[r_grant_id] = 1'b1;
            end
        end
    end

    assign w_sel_idx  = (r_state == ST_HOLD) ? r_grant_id : w_arb_idx;
    assign w_sel_last = i_req_last[w_sel_idx];
    assign w_ptr_next = (r_grant_id == IDX_W'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_sel_idx == IDX_W'(i)) begin
                w_sel_data = i_req_data[i*UART_BYTE_W +: UART_BYTE_W];
            end
        end
    end

    // the transmitter has no done output, so frame end is inferred from baud ticks
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_tx_en    <= 1'b0;
            r_tx_data  <= '0;
            r_grant_id <= '0;
            r_ptr      <= '0;
            r_lock     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_tx_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_any) begin
                        r_tx_data  <= w_sel_data;
                        r_grant_id <= w_arb_idx;
                        r_lock     <= !w_sel_last;
                        r_tx_en    <= 1'b1;
                        r_state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_tick) begin
                        if (r_cnt == CNT_W'(FRAME_TICKS - 1)) begin
                            r_cnt <= '0;
                            if (r_lock) begin
                                r_state <= ST_HOLD;
                            end else begin
                                r_ptr   <= w_ptr_next;
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    // an owner byte beats a coincident timeout tick
                    if (i_req_valid[r_grant_id]) begin
                        r_tx_data <= w_sel_data;
                        r_lock    <= !w_sel_last;
                        r_tx_en   <= 1'b1;
                        r_state   <= ST_SEND;
                    end else if (i_tick) begin
                        if (r_cnt == CNT_W'(HOLD_TICKS - 1)) begin
                            r_cnt   <= '0;
                            r_lock  <= 1'b0;
                            r_ptr   <= w_ptr_next;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_req_ready = w_ready;
    assign o_tx_en     = r_tx_en;
    assign o_tx_data   = r_tx_data;
    assign o_grant_id  = r_grant_id;
    assign o_busy      = (r_state != ST_IDLE);

endmodule
